// File: rtl/video_timing_monitor.sv
// Sink-side VGA timing checker: measures line/frame geometry, tracks lock over
// consecutive conforming frames and counts bad frames and grid-pattern pixel errors.
module video_timing_monitor #(
    parameter int unsigned HDISP       = 800,
    parameter int unsigned VDISP       = 480,
    parameter int unsigned HTOTAL      = 928,
    parameter int unsigned VTOTAL      = 525,
    parameter int unsigned LOCK_FRAMES = 2
) (
    input  logic        pixel_clk,
    input  logic        pixel_rst_n,
    input  logic        hs,
    input  logic        vs,
    input  logic        blank,
    input  logic [23:0] rgb,
    input  logic        check_en,
    input  logic        clr,
    output logic        locked,
    output logic        frame_done,
    output logic [15:0] frame_cnt,
    output logic [15:0] err_cnt,
    output logic [15:0] pix_err_cnt,
    output logic [10:0] meas_h_total,
    output logic [10:0] meas_h_active,
    output logic [10:0] meas_v_total,
    output logic [10:0] meas_v_active
);

    localparam int unsigned CW = 11;
    localparam int unsigned SW = 16;
    localparam int unsigned GW = 4;
    localparam logic [23:0] PIX_WHITE = 24'hFFFFFF;
    localparam logic [23:0] PIX_BLACK = 24'h000000;

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic [GW-1:0] good, good_nxt;
    logic          frame_inc, err_inc;

    logic          hs_q, vs_q;
    logic          hfall, vfall;
    logic [CW-1:0] cnt_h, act_h, cnt_v, act_v;
    logic          line_bad;

    logic          line_err;
    logic [CW-1:0] cnt_v_close, act_v_close;
    logic          line_bad_close;
    logic          frame_ok;
    logic [23:0]   pix_exp;
    logic          pix_mis;

    assign hfall = hs_q & ~hs;
    assign vfall = vs_q & ~vs;

    // Line closing folded in first so a same-cycle vfall sees the finished line
    always_comb begin
        line_err       = (cnt_h != CW'(HTOTAL)) ||
                         ((act_h != '0) && (act_h != CW'(HDISP)));
        cnt_v_close    = hfall ? cnt_v + CW'(1) : cnt_v;
        act_v_close    = (hfall && (act_h != '0)) ? act_v + CW'(1) : act_v;
        line_bad_close = line_bad | (hfall & line_err);
        frame_ok       = !line_bad_close &&
                         (cnt_v_close == CW'(VTOTAL)) &&
                         (act_v_close == CW'(VDISP));
    end

    // Grid reference: white on every 16th column and row
    always_comb begin
        pix_exp = ((act_h[3:0] == 4'd0) || (act_v[3:0] == 4'd0)) ? PIX_WHITE : PIX_BLACK;
        pix_mis = blank && check_en && (rgb != pix_exp);
    end

    always_ff @(posedge pixel_clk or negedge pixel_rst_n) begin
        if (!pixel_rst_n) begin
            state <= SEARCH;
            good  <= '0;
        end else begin
            state <= state_nxt;
            good  <= good_nxt;
        end
    end

    // Lock FSM, advanced only at frame boundaries
    always_comb begin
        state_nxt = state;
        good_nxt  = good;
        frame_inc = 1'b0;
        err_inc   = 1'b0;
        if (vfall) begin
            case (state)
                SEARCH: begin
                    state_nxt = ACQUIRE;
                    good_nxt  = '0;
                end
                ACQUIRE: begin
                    frame_inc = 1'b1;
                    if (frame_ok) begin
                        good_nxt = good + GW'(1);
                        if ((good + GW'(1)) >= GW'(LOCK_FRAMES)) begin
                            state_nxt = LOCKED;
                        end
                    end else begin
                        good_nxt = '0;
                        err_inc  = 1'b1;
                    end
                end
                LOCKED: begin
                    frame_inc = 1'b1;
                    if (!frame_ok) begin
                        err_inc   = 1'b1;
                        good_nxt  = '0;
                        state_nxt = ACQUIRE;
                    end
                end
                default: begin
                    state_nxt = SEARCH;
                    good_nxt  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge pixel_clk or negedge pixel_rst_n) begin
        if (!pixel_rst_n) begin
            hs_q          <= 1'b1;
            vs_q          <= 1'b1;
            cnt_h         <= '0;
            act_h         <= '0;
            cnt_v         <= '0;
            act_v         <= '0;
            line_bad      <= 1'b0;
            meas_h_total  <= '0;
            meas_h_active <= '0;
            meas_v_total  <= '0;
            meas_v_active <= '0;
        end else begin
            hs_q <= hs;
            vs_q <= vs;

            if (hfall) begin
                cnt_h         <= CW'(1);
                act_h         <= '0;
                meas_h_total  <= cnt_h;
                meas_h_active <= act_h;
            end else begin
                if (cnt_h != '1) begin
                    cnt_h <= cnt_h + CW'(1);
                end
                if (blank && (act_h != '1)) begin
                    act_h <= act_h + CW'(1);
                end
            end

            if (vfall) begin
                meas_v_total  <= cnt_v_close;
                meas_v_active <= act_v_close;
                cnt_v         <= '0;
                act_v         <= '0;
                line_bad      <= 1'b0;
            end else begin
                cnt_v    <= cnt_v_close;
                act_v    <= act_v_close;
                line_bad <= line_bad_close;
            end
        end
    end

    // Status counters; clr wins over a same-cycle increment
    always_ff @(posedge pixel_clk or negedge pixel_rst_n) begin
        if (!pixel_rst_n) begin
            locked      <= 1'b0;
            frame_done  <= 1'b0;
            frame_cnt   <= '0;
            err_cnt     <= '0;
            pix_err_cnt <= '0;
        end else begin
            locked     <= (state_nxt == LOCKED);
            frame_done <= frame_inc;
            if (clr) begin
                frame_cnt   <= '0;
                err_cnt     <= '0;
                pix_err_cnt <= '0;
            end else begin
                if (frame_inc) begin
                    frame_cnt <= frame_cnt + SW'(1);
                end
                if (err_inc && (err_cnt != '1)) begin
                    err_cnt <= err_cnt + SW'(1);
                end
                if (pix_mis && (pix_err_cnt != '1)) begin
                    pix_err_cnt <= pix_err_cnt + SW'(1);
                end
            end
        end
    end

endmodule
